inv_substitution_layer_seq: RTL and testbench

- Iterative inverse ASCON substitution layer: applies the inverse 5-bit S-box to all 64 columns of a 320-bit state, SBOX_PER_CYCLE columns per clock.
- Other direction of the forward substitution layer. Used by the decryption-side verification/debug datapath and by the self-check harness, which round-trips a state through the forward layer and back.
- Handshake: valid/ready on input and on output.
- Area is traded for latency: SBOX_PER_CYCLE inverse S-box instances, reused across passes.

---
 rtl/inv_substitution_layer_seq.sv | 134 +++++++++++++
 tb/tb_inv_substitution_layer_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_substitution_layer_seq.sv
// Iterative inverse ASCON substitution layer: inverts all 64 columns of a
// 320-bit state with SBOX_PER_CYCLE inverse S-boxes reused over 64/P passes.
package ascon_pkg;
    localparam int unsigned NUM_SBOXES = 64;
    localparam int unsigned NUM_WORDS  = 5;

    typedef logic [NUM_WORDS-1:0][NUM_SBOXES-1:0] t_state_array;
endpackage

module inv_substitution_layer_seq
    import ascon_pkg::*;
#(
    parameter int unsigned SBOX_PER_CYCLE = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  t_state_array i_state,
    output logic         o_valid,
    input  logic         i_ready,
    output t_state_array o_state
);

    localparam int unsigned NUM_CHUNKS = NUM_SBOXES / SBOX_PER_CYCLE;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned COL_W      = $clog2(NUM_SBOXES);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    localparam logic [4:0] INV_SBOX [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    // Only power-of-two chunk sizes that divide the state evenly are supported
    if (!(SBOX_PER_CYCLE == 1  || SBOX_PER_CYCLE == 2  || SBOX_PER_CYCLE == 4 ||
          SBOX_PER_CYCLE == 8  || SBOX_PER_CYCLE == 16 || SBOX_PER_CYCLE == 32 ||
          SBOX_PER_CYCLE == 64)) begin : g_bad_sbox_per_cycle
        $error("inv_substitution_layer_seq: SBOX_PER_CYCLE must be 1,2,4,8,16,32 or 64");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    t_state_array     work_q, work_d;
    t_state_array     chunk_sub;
    t_state_array     o_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             o_valid_d;

    // Working state with the current chunk of columns replaced by INV values
    always_comb begin
        logic [COL_W-1:0] col;
        logic [4:0]       x;
        logic [4:0]       y;
        chunk_sub = work_q;
        col       = '0;
        x         = '0;
        y         = '0;
        for (int unsigned j = 0; j < SBOX_PER_CYCLE; j++) begin
            col = COL_W'(32'(cnt_q) * SBOX_PER_CYCLE + j);
            x   = {work_q[0][col], work_q[1][col], work_q[2][col],
                   work_q[3][col], work_q[4][col]};
            y   = INV_SBOX[x];
            chunk_sub[0][col] = y[4];
            chunk_sub[1][col] = y[3];
            chunk_sub[2][col] = y[2];
            chunk_sub[3][col] = y[1];
            chunk_sub[4][col] = y[0];
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        o_valid_d = o_valid;
        o_state_d = o_state;
        o_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    work_d  = i_state;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = chunk_sub;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d     = '0;
                    o_state_d = chunk_sub;
                    o_valid_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    o_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            o_valid <= 1'b0;
            o_state <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            o_valid <= o_valid_d;
            o_state <= o_state_d;
        end
    end

endmodule

// File: tb/tb_inv_substitution_layer_seq.sv
// Randomized self-checking bench for inv_substitution_layer_seq at P=8, 1 and 64,
// using a forward S-box model and a search-based inverse as reference.
module tb_inv_substitution_layer_seq;
    import ascon_pkg::*;

    localparam logic [4:0] FWD [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam logic [4:0] INV_TBL [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    logic         clock;
    logic         reset_n;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic         out_valid [3];
    logic         ds_ready  [3];
    t_state_array in_state  [3];
    t_state_array out_state [3];

    int errors = 0;
    int checks = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    inv_substitution_layer_seq #(.SBOX_PER_CYCLE(8)) dut_p8 (
        .clock(clock), .reset_n(reset_n),
        .i_valid(in_valid[0]), .o_ready(out_ready[0]), .i_state(in_state[0]),
        .o_valid(out_valid[0]), .i_ready(ds_ready[0]), .o_state(out_state[0])
    );
    inv_substitution_layer_seq #(.SBOX_PER_CYCLE(1)) dut_p1 (
        .clock(clock), .reset_n(reset_n),
        .i_valid(in_valid[1]), .o_ready(out_ready[1]), .i_state(in_state[1]),
        .o_valid(out_valid[1]), .i_ready(ds_ready[1]), .o_state(out_state[1])
    );
    inv_substitution_layer_seq #(.SBOX_PER_CYCLE(64)) dut_p64 (
        .clock(clock), .reset_n(reset_n),
        .i_valid(in_valid[2]), .o_ready(out_ready[2]), .i_state(in_state[2]),
        .o_valid(out_valid[2]), .i_ready(ds_ready[2]), .o_state(out_state[2])
    );

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] get_col(input t_state_array s, input int i);
        return {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
    endfunction

    function automatic t_state_array set_col(input t_state_array s, input int i, input logic [4:0] v);
        t_state_array r = s;
        r[0][i] = v[4];
        r[1][i] = v[3];
        r[2][i] = v[2];
        r[3][i] = v[1];
        r[4][i] = v[0];
        return r;
    endfunction

    function automatic t_state_array fwd_layer(input t_state_array s);
        t_state_array r = s;
        for (int i = 0; i < 64; i++) r = set_col(r, i, FWD[get_col(s, i)]);
        return r;
    endfunction

    // Inverse obtained by searching the forward table, independent of INV_TBL
    function automatic t_state_array inv_layer(input t_state_array s);
        t_state_array r = s;
        logic [4:0]   y;
        for (int i = 0; i < 64; i++) begin
            y = '0;
            for (int j = 0; j < 32; j++) if (FWD[j] == get_col(s, i)) y = 5'(j);
            r = set_col(r, i, y);
        end
        return r;
    endfunction

    function automatic t_state_array rand_state();
        t_state_array r;
        for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
        return r;
    endfunction

    // One accept/compute/drain transaction on DUT d; returns result and latency
    task automatic xact(input int d, input t_state_array s, output t_state_array r, output int lat);
        check($sformatf("accept_ready_%0d", d), 320'(out_ready[d]), 320'(1'b1));
        in_state[d] = s;
        in_valid[d] = 1'b1;
        ds_ready[d] = 1'b1;
        @(posedge clock); #1;
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        r = out_state[d];
        @(posedge clock); #1;
    endtask

    task automatic round_trip(input int d, input int exp_lat);
        t_state_array s, r;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            s = rand_state();
            xact(d, fwd_layer(s), r, lat);
            check($sformatf("rt_data_p%0d", 64 / exp_lat), r, s);
            check($sformatf("rt_lat_p%0d", 64 / exp_lat), 320'(lat), 320'(exp_lat));
        end
    endtask

    initial begin
        t_state_array s, r, e;
        t_state_array acc_st [$];
        int lat;
        int prev;

        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0;
            ds_ready[d] = 1'b0;
            in_state[d] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid_%0d", d), 320'(out_valid[d]), 320'(1'b0));
            check($sformatf("rst_state_%0d", d), out_state[d], '0);
            check($sformatf("rst_ready_%0d", d), 320'(out_ready[d]), 320'(1'b1));
        end
        reset_n = 1'b1;
        @(posedge clock); #1;

        // All-zero state: every column becomes 0x14
        xact(0, '0, r, lat);
        e = '0;
        e[0] = '1;
        e[2] = '1;
        check("zero_lat", 320'(lat), 320'(8));
        check("zero_data", r, e);

        // All-ones state with downstream stall
        in_state[0] = '1;
        in_valid[0] = 1'b1;
        ds_ready[0] = 1'b0;
        @(posedge clock); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        check("ones_lat", 320'(lat), 320'(8));
        e = '0;
        e[3] = '1;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 320'(out_valid[0]), 320'(1'b1));
            check("stall_data", out_state[0], e);
            check("stall_ready", 320'(out_ready[0]), 320'(1'b0));
            @(posedge clock); #1;
        end
        ds_ready[0] = 1'b1;
        @(posedge clock); #1;
        check("release_valid", 320'(out_valid[0]), 320'(1'b0));
        check("release_ready", 320'(out_ready[0]), 320'(1'b1));
        check("release_hold", out_state[0], e);

        // Exhaustive table: column i of state n holds (n+i) mod 32
        for (int n = 0; n < 32; n++) begin
            s = '0;
            e = '0;
            for (int i = 0; i < 64; i++) begin
                s = set_col(s, i, 5'((n + i) % 32));
                e = set_col(e, i, INV_TBL[5'((n + i) % 32)]);
            end
            xact(0, s, r, lat);
            check($sformatf("table_%0d", n), r, e);
        end

        // Reset in the middle of BUSY
        in_state[0] = rand_state();
        in_valid[0] = 1'b1;
        @(posedge clock); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 320'(out_valid[0]), 320'(1'b0));
        check("midrst_state", out_state[0], '0);
        check("midrst_ready", 320'(out_ready[0]), 320'(1'b1));
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("postrst_valid", 320'(out_valid[0]), 320'(1'b0));
        check("postrst_ready", 320'(out_ready[0]), 320'(1'b1));
        s = rand_state();
        xact(0, s, r, lat);
        check("postrst_data", r, inv_layer(s));
        check("postrst_lat", 320'(lat), 320'(8));

        // Continuous valid with input churning during BUSY
        prev = -1;
        ds_ready[0] = 1'b1;
        in_valid[0] = 1'b1;
        for (int cyc = 0; cyc < 55; cyc++) begin
            in_state[0] = rand_state();
            if (out_ready[0]) begin
                if (prev >= 0) check("proto_gap", 320'(cyc - prev), 320'(10));
                prev = cyc;
                acc_st.push_back(in_state[0]);
            end
            if (out_valid[0]) begin
                if (acc_st.size() > 0) check("proto_data", out_state[0], inv_layer(acc_st.pop_front()));
                else check("proto_orphan", 320'(out_valid[0]), 320'(1'b0));
            end
            @(posedge clock); #1;
        end
        in_valid[0] = 1'b0;
        repeat (12) @(posedge clock);
        #1;

        // Forward layer then inverse layer must be the identity
        fork
            round_trip(0, 8);
            round_trip(1, 64);
            round_trip(2, 1);
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
